ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage LoongArch pipeline, sitting between the decode stage and the memory stage. It registers the decoded instruction and computes the ALU result. For loads and stores it generates the data-SRAM request under a req/addr_ok handshake. It forwards the register-file bus, the load type, the exception bus and a "request issued" flag to the memory stage.

## Interface
Parameters:
- none.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ID_EX_valid`  in  1  decode stage presents a valid instruction.
- `EX_allowin`  out  1  EX can accept an instruction this cycle.
- `ID_pc`  in  32  PC of the incoming instruction.
- `ID_alu_op`  in  12  one-hot operation select `{add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}`.
- `ID_alu_src1`, `ID_alu_src2`  in  32 each  ALU operands.
- `ID_rkd_value`  in  32  store data.
- `ID_st_op`  in  3  store type `{st_w,st_h,st_b}`.
- `ID_mem_ld_inst`  in  5  load type `{ld_w,ld_b,ld_h,ld_bu,ld_hu}`.
- `ID_ctrl`  in  8  control fields `{csr_re,res_from_mem,rf_we,rf_waddr[4:0]}`.
- `ID_except_bus`  in  86  exception/CSR bus; bit 85 is the ALE slot.
- `MEM_allowin`  in  1  memory stage can accept.
- `MEM_EXC_signal`, `WB_EXC_signal`  in  1 each  exception pending in MEM / flush from WB.
- `EX_MEM_valid`  out  1  valid instruction offered to MEM.
- `EX_pc`  out  32  PC of the EX instruction.
- `EX_rf_bus`  out  40  `{csr_re,res_from_mem,rf_we,rf_waddr,alu_result}`.
- `EX_mem_ld_inst`  out  5  registered load type.
- `EX_req`  out  1  a data request for this instruction was accepted (`addr_ok` seen); MEM must wait for `data_ok`.
- `EX_except_bus`  out  86  registered exception bus with bit 85 (ALE) merged in.
- `data_sram_req`, `data_sram_wr`  out  1 each  request / write select.
- `data_sram_size`  out  2  transfer size.
- `data_sram_wstrb`  out  4  byte write strobes.
- `data_sram_addr`, `data_sram_wdata`  out  32 each  address / write data.
- `data_sram_addr_ok`  in  1  address handshake.

## Operation
- Pipeline register:
  - Loads all ID fields when `ID_EX_valid & EX_allowin`.
  - `EX_valid` is cleared on `WB_EXC_signal`; otherwise it loads `ID_EX_valid` when `EX_allowin`.
- ALU:
  - Purely combinational from the registered operands.
  - Shifts use `src2[4:0]`; `sra` is arithmetic.
  - `slt` is signed, `sltu` unsigned, with the result in bit 0.
  - `lui` passes `src2`.
- Memory op: `mem_op = |ld | |st`. The address is `alu_result`.
- Size and strobes:
  - `size` is 0/1/2 for b/h/w.
  - `wstrb = st_b ? 4'b1<<addr[1:0] : st_h ? 4'b11<<addr[1:0] : st_w ? 4'hf : 0`.
- Write data: replicated as `{4{b}}`, `{2{h}}` or `w`.
- ALE: raised for a half-word op when `addr[0]=1`, or a word op when `addr[1:0]!=0`.
- Request FSM:
  - IDLE → REQ on `EX_valid & mem_op & ~cancel`, where `cancel = ALE | MEM_EXC_signal | WB_EXC_signal | |EX_except_bus`.
  - REQ → DONE on `addr_ok`.
  - DONE → IDLE when the instruction leaves EX or on flush.
  - `data_sram_req = (state==IDLE & EX_valid & mem_op & ~cancel) | state==REQ`.
  - Once asserted, `req`, `addr`, `wdata`, `wstrb` and `size` hold stable until `addr_ok`, even across `WB_EXC_signal`. On a flush in REQ, the FSM completes the handshake and then returns to IDLE with the stage empty.
- Ready/go: `EX_ready_go = ~mem_op | cancel | state==DONE | data_sram_req & addr_ok`.
- Stage flow:
  - `EX_allowin = ~EX_valid | EX_ready_go & MEM_allowin`.
  - `EX_MEM_valid = EX_valid & EX_ready_go`.
- `EX_req = mem_op & ~cancel & (state==DONE | data_sram_req & addr_ok)`.
- `EX_rf_bus` masks `rf_we` and `csr_re` with `EX_valid`.

## Timing
- Reset:
  - `EX_valid=0`, FSM=IDLE, all registered fields 0.
  - Hence `EX_MEM_valid=0`, `data_sram_req=0`, `EX_req=0`, `EX_pc=0`, `EX_except_bus=0`.
  - `EX_allowin=1`.
- Latency:
  - Non-memory ops: 1 cycle in EX.
  - Memory ops: 1 cycle if `addr_ok` arrives in the issue cycle; otherwise 1 + cycles waiting for `addr_ok`.
- Zero-wait path: `addr_ok` in the same cycle as `req` gives `ready_go` the same cycle.
- MEM stalled after `addr_ok`: FSM sits in DONE, no second request is issued, and `EX_req` stays 1.
- Simultaneous events:
  - `WB_EXC_signal` and `ID_EX_valid` together: `EX_valid` becomes 0, and the flush wins.
  - `MEM_EXC_signal` rising in IDLE suppresses the request.
  - Reset mid-REQ drops `req` immediately (asynchronous).

## Configuration
- `EX_ALE_CHECK_EN` defined: ALE detection as above. A misaligned access raises bit 85, issues no request, and gives `EX_req=0`.
- Undefined: ALE is forced to 0. Misaligned accesses are issued with the unaligned address and byte strobes shifted as computed (truncated to 4 bits).

## Test plan
- Non-memory ops:
  - Stimulus: add with `0x7fffffff + 1`.
  - Response: `EX_rf_bus[31:0]=0x80000000` and `EX_MEM_valid` one cycle after entry.
- Store byte:
  - Stimulus: `st_b` to address `0x1003`, data `0xAB`, `addr_ok` same cycle.
  - Response: `wstrb=4'b1000`, `wdata=0xABABABAB`, `size=0`, `EX_req=1`, `ready_go` same cycle.
- Load word with 3 wait cycles of `addr_ok=0`:
  - Response: `req` held 4 cycles with the address stable.
  - Response: `EX_MEM_valid` rises in the `addr_ok` cycle.
  - Response: with `MEM_allowin=0` for 2 more cycles, no second `req` is issued.
- `ld_h` at `0x2001` with `EX_ALE_CHECK_EN`:
  - Response: bit 85 = 1, `data_sram_req` never asserted, `EX_req=0`.
  - Without the macro: `req=1`, `size=1`.
- Flush:
  - Stimulus: `WB_EXC_signal` while in REQ.
  - Response: `req` held until `addr_ok`, then `EX_valid=0` and FSM in IDLE, with no `EX_MEM_valid`.
- Reset:
  - Stimulus: `reset` asserted mid-DONE.
  - Response: all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - LoongArch execute stage: ALU, data-SRAM request handshake, EX/MEM register
//
// Purpose:
//   Registers the decoded instruction from ID, computes the ALU result and, for
//   loads/stores, drives the data-SRAM request under a req/addr_ok handshake.
//   Forwards the register-file bus, load type, exception bus and a
//   "request accepted" flag to MEM.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   ID_EX_valid / EX_allowin        ID->EX handshake
//   ID_pc, ID_alu_op, ID_alu_src1,
//   ID_alu_src2, ID_rkd_value,
//   ID_st_op, ID_mem_ld_inst,
//   ID_ctrl, ID_except_bus          decoded instruction fields
//   MEM_allowin / EX_MEM_valid      EX->MEM handshake
//   MEM_EXC_signal, WB_EXC_signal   exception pending in MEM / flush from WB
//   EX_pc, EX_rf_bus,
//   EX_mem_ld_inst, EX_req,
//   EX_except_bus                   fields forwarded to MEM
//   data_sram_*                     data-SRAM request channel
//
// Configuration:
//   EX_ALE_CHECK_EN  when defined, misaligned half-word/word accesses raise the
//                    ALE bit (85) of the exception bus and are not issued.

module ex_stage (
    input  logic        clk,
    input  logic        reset,

    input  logic        ID_EX_valid,
    output logic        EX_allowin,
    input  logic [31:0] ID_pc,
    input  logic [11:0] ID_alu_op,
    input  logic [31:0] ID_alu_src1,
    input  logic [31:0] ID_alu_src2,
    input  logic [31:0] ID_rkd_value,
    input  logic [2:0]  ID_st_op,
    input  logic [4:0]  ID_mem_ld_inst,
    input  logic [7:0]  ID_ctrl,
    input  logic [85:0] ID_except_bus,

    input  logic        MEM_allowin,
    input  logic        MEM_EXC_signal,
    input  logic        WB_EXC_signal,

    output logic        EX_MEM_valid,
    output logic [31:0] EX_pc,
    output logic [39:0] EX_rf_bus,
    output logic [4:0]  EX_mem_ld_inst,
    output logic        EX_req,
    output logic [85:0] EX_except_bus,

    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } req_state_e;

    req_state_e  state_q;

    logic        ex_valid_q;
    logic        ex_valid_d;
    logic [31:0] pc_q;
    logic [11:0] alu_op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] rkd_q;
    logic [2:0]  st_op_q;
    logic [4:0]  ld_q;
    logic [7:0]  ctrl_q;
    logic [85:0] except_q;

    logic        id_load;
    logic        ex_ready_go;
    logic        stage_out;
    logic        req_pending;
    logic        mem_op;
    logic        cancel;
    logic        ale;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] alu_result;

    assign add_res  = src1_q + src2_q;
    assign sub_res  = src1_q - src2_q;
    assign slt_res  = $signed(src1_q) < $signed(src2_q);
    assign sltu_res = src1_q < src2_q;
    assign sll_res  = src1_q << src2_q[4:0];
    assign srl_res  = src1_q >> src2_q[4:0];
    assign sra_res  = $signed(src1_q) >>> src2_q[4:0];

    // alu_op is one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
    assign alu_result = ({32{alu_op_q[11]}} & add_res)
                      | ({32{alu_op_q[10]}} & sub_res)
                      | ({32{alu_op_q[9]}}  & {31'd0, slt_res})
                      | ({32{alu_op_q[8]}}  & {31'd0, sltu_res})
                      | ({32{alu_op_q[7]}}  & (src1_q & src2_q))
                      | ({32{alu_op_q[6]}}  & ~(src1_q | src2_q))
                      | ({32{alu_op_q[5]}}  & (src1_q | src2_q))
                      | ({32{alu_op_q[4]}}  & (src1_q ^ src2_q))
                      | ({32{alu_op_q[3]}}  & sll_res)
                      | ({32{alu_op_q[2]}}  & srl_res)
                      | ({32{alu_op_q[1]}}  & sra_res)
                      | ({32{alu_op_q[0]}}  & src2_q);

    // ------------------------------------------------------------------
    // Memory access decode
    // ------------------------------------------------------------------
    logic st_w, st_h, st_b;
    logic ld_w, ld_b, ld_h, ld_bu, ld_hu;
    logic half_op;
    logic word_op;

    assign {st_w, st_h, st_b}              = st_op_q;
    assign {ld_w, ld_b, ld_h, ld_bu, ld_hu} = ld_q;

    assign mem_op  = (|ld_q) | (|st_op_q);
    assign half_op = ld_h | ld_hu | st_h;
    assign word_op = ld_w | st_w;

    assign data_sram_addr = alu_result;
    assign data_sram_wr   = |st_op_q;
    assign data_sram_size = word_op ? 2'd2 : (half_op ? 2'd1 : 2'd0);

    // Strobes shift with the low address bits; a misaligned half-word at
    // offset 3 (only issued when ALE checking is off) truncates to 4'b1000.
    assign data_sram_wstrb = st_b ? (4'b0001 << data_sram_addr[1:0]) :
                             st_h ? (4'b0011 << data_sram_addr[1:0]) :
                             st_w ? 4'hf : 4'h0;

    assign data_sram_wdata = st_b ? {4{rkd_q[7:0]}}  :
                             st_h ? {2{rkd_q[15:0]}} : rkd_q;

`ifdef EX_ALE_CHECK_EN
    assign ale = ex_valid_q & ((half_op & data_sram_addr[0]) |
                               (word_op & (|data_sram_addr[1:0])));
`else
    assign ale = 1'b0;
`endif

    assign EX_except_bus = {except_q[85] | ale, except_q[84:0]};

    // Any pending exception (own, ALE, downstream or flush) kills the access.
    assign cancel = MEM_EXC_signal | WB_EXC_signal | (|EX_except_bus);

    // A request already on the bus cannot be withdrawn; REQ keeps it asserted
    // regardless of cancel until addr_ok.
    assign data_sram_req = ((state_q == S_IDLE) & ex_valid_q & mem_op & ~cancel)
                         | (state_q == S_REQ);

    // ------------------------------------------------------------------
    // Stage flow
    // ------------------------------------------------------------------
    assign ex_ready_go = ~mem_op | cancel | (state_q == S_DONE)
                       | (data_sram_req & data_sram_addr_ok);

    // While an unacknowledged request is outstanding the pipeline register
    // must not be overwritten, otherwise addr/wdata/wstrb would change under
    // a live request (this only bites when cancel releases ready_go).
    assign req_pending = (state_q == S_REQ) & ~data_sram_addr_ok;

    assign EX_allowin   = (~ex_valid_q | (ex_ready_go & MEM_allowin)) & ~req_pending;
    assign EX_MEM_valid = ex_valid_q & ex_ready_go;

    // The current instruction is finished with EX: it moves on, is flushed,
    // or the stage is already empty (flushed while a request was in flight).
    assign stage_out = ~ex_valid_q | (ex_ready_go & MEM_allowin) | WB_EXC_signal;

    assign EX_req = ex_valid_q & mem_op & ~cancel
                  & ((state_q == S_DONE) | (data_sram_req & data_sram_addr_ok));

    assign EX_pc          = pc_q;
    assign EX_mem_ld_inst = ld_q;
    assign EX_rf_bus      = {ctrl_q[7] & ex_valid_q, ctrl_q[6],
                             ctrl_q[5] & ex_valid_q, ctrl_q[4:0], alu_result};

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    assign id_load = ID_EX_valid & EX_allowin;

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (WB_EXC_signal) begin
            ex_valid_d = 1'b0;
        end else if (EX_allowin) begin
            ex_valid_d = ID_EX_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            pc_q       <= 32'd0;
            alu_op_q   <= 12'd0;
            src1_q     <= 32'd0;
            src2_q     <= 32'd0;
            rkd_q      <= 32'd0;
            st_op_q    <= 3'd0;
            ld_q       <= 5'd0;
            ctrl_q     <= 8'd0;
            except_q   <= 86'd0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (id_load) begin
                pc_q     <= ID_pc;
                alu_op_q <= ID_alu_op;
                src1_q   <= ID_alu_src1;
                src2_q   <= ID_alu_src2;
                rkd_q    <= ID_rkd_value;
                st_op_q  <= ID_st_op;
                ld_q     <= ID_mem_ld_inst;
                ctrl_q   <= ID_ctrl;
                except_q <= ID_except_bus;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    // IDLE with a zero-wait handshake skips REQ; if the instruction cannot
    // leave yet it parks in DONE so no second request is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (data_sram_req) begin
                        if (!data_sram_addr_ok) begin
                            state_q <= S_REQ;
                        end else if (!stage_out) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (data_sram_addr_ok) begin
                        state_q <= stage_out ? S_IDLE : S_DONE;
                    end
                end
                S_DONE: begin
                    if (stage_out) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_EX_valid;
    logic        EX_allowin;
    logic [31:0] ID_pc;
    logic [11:0] ID_alu_op;
    logic [31:0] ID_alu_src1;
    logic [31:0] ID_alu_src2;
    logic [31:0] ID_rkd_value;
    logic [2:0]  ID_st_op;
    logic [4:0]  ID_mem_ld_inst;
    logic [7:0]  ID_ctrl;
    logic [85:0] ID_except_bus;
    logic        MEM_allowin;
    logic        MEM_EXC_signal;
    logic        WB_EXC_signal;
    logic        EX_MEM_valid;
    logic [31:0] EX_pc;
    logic [39:0] EX_rf_bus;
    logic [4:0]  EX_mem_ld_inst;
    logic        EX_req;
    logic [85:0] EX_except_bus;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;

    ex_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ID_EX_valid      (ID_EX_valid),
        .EX_allowin       (EX_allowin),
        .ID_pc            (ID_pc),
        .ID_alu_op        (ID_alu_op),
        .ID_alu_src1      (ID_alu_src1),
        .ID_alu_src2      (ID_alu_src2),
        .ID_rkd_value     (ID_rkd_value),
        .ID_st_op         (ID_st_op),
        .ID_mem_ld_inst   (ID_mem_ld_inst),
        .ID_ctrl          (ID_ctrl),
        .ID_except_bus    (ID_except_bus),
        .MEM_allowin      (MEM_allowin),
        .MEM_EXC_signal   (MEM_EXC_signal),
        .WB_EXC_signal    (WB_EXC_signal),
        .EX_MEM_valid     (EX_MEM_valid),
        .EX_pc            (EX_pc),
        .EX_rf_bus        (EX_rf_bus),
        .EX_mem_ld_inst   (EX_mem_ld_inst),
        .EX_req           (EX_req),
        .EX_except_bus    (EX_except_bus),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_wstrb  (data_sram_wstrb),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one instruction for one cycle; returns 1 time unit after the
    // edge that latched it (first EX cycle).
    task automatic send(input logic [31:0] pc, input logic [11:0] op,
                        input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] rkd, input logic [2:0] st,
                        input logic [4:0] ld, input logic [7:0] ctrl,
                        input logic [85:0] exc);
        ID_pc          = pc;
        ID_alu_op      = op;
        ID_alu_src1    = s1;
        ID_alu_src2    = s2;
        ID_rkd_value   = rkd;
        ID_st_op       = st;
        ID_mem_ld_inst = ld;
        ID_ctrl        = ctrl;
        ID_except_bus  = exc;
        ID_EX_valid    = 1'b1;
        @(posedge clk);
        #1;
        ID_EX_valid    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [11:0] OP_ADD = 12'h800;

    logic [11:0] v_op  [12];
    logic [31:0] v_s1  [12];
    logic [31:0] v_s2  [12];
    logic [31:0] v_res [12];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v_op[0]  = 12'h800; v_s1[0]  = 32'h7fffffff; v_s2[0]  = 32'h00000001; v_res[0]  = 32'h80000000;
        v_op[1]  = 12'h400; v_s1[1]  = 32'd5;        v_s2[1]  = 32'd7;        v_res[1]  = 32'hfffffffe;
        v_op[2]  = 12'h200; v_s1[2]  = 32'hffffffff; v_s2[2]  = 32'd1;        v_res[2]  = 32'd1;
        v_op[3]  = 12'h100; v_s1[3]  = 32'hffffffff; v_s2[3]  = 32'd1;        v_res[3]  = 32'd0;
        v_op[4]  = 12'h080; v_s1[4]  = 32'hf0f0ff00; v_s2[4]  = 32'h0ff0f0f0; v_res[4]  = 32'h00f0f000;
        v_op[5]  = 12'h040; v_s1[5]  = 32'hf0f0ff00; v_s2[5]  = 32'h0ff0f0f0; v_res[5]  = 32'h000f000f;
        v_op[6]  = 12'h020; v_s1[6]  = 32'hf0f0ff00; v_s2[6]  = 32'h0ff0f0f0; v_res[6]  = 32'hfff0fff0;
        v_op[7]  = 12'h010; v_s1[7]  = 32'hf0f0ff00; v_s2[7]  = 32'h0ff0f0f0; v_res[7]  = 32'hff000ff0;
        v_op[8]  = 12'h008; v_s1[8]  = 32'h00000001; v_s2[8]  = 32'h00000023; v_res[8]  = 32'h00000008;
        v_op[9]  = 12'h004; v_s1[9]  = 32'h80000000; v_s2[9]  = 32'd4;        v_res[9]  = 32'h08000000;
        v_op[10] = 12'h002; v_s1[10] = 32'h80000000; v_s2[10] = 32'd4;        v_res[10] = 32'hf8000000;
        v_op[11] = 12'h001; v_s1[11] = 32'hdeadbeef; v_s2[11] = 32'h12345000; v_res[11] = 32'h12345000;

        reset             = 1'b1;
        ID_EX_valid       = 1'b0;
        ID_pc             = 32'd0;
        ID_alu_op         = 12'd0;
        ID_alu_src1       = 32'd0;
        ID_alu_src2       = 32'd0;
        ID_rkd_value      = 32'd0;
        ID_st_op          = 3'd0;
        ID_mem_ld_inst    = 5'd0;
        ID_ctrl           = 8'd0;
        ID_except_bus     = 86'd0;
        MEM_allowin       = 1'b1;
        MEM_EXC_signal    = 1'b0;
        WB_EXC_signal     = 1'b0;
        data_sram_addr_ok = 1'b0;

        // Reset state
        #2;
        check("rst_allowin",  EX_allowin,    1'b1);
        check("rst_memvalid", EX_MEM_valid,  1'b0);
        check("rst_req",      data_sram_req, 1'b0);
        check("rst_ex_req",   EX_req,        1'b0);
        check("rst_pc",       EX_pc,         32'd0);
        check("rst_exc",      EX_except_bus, 86'd0);
        tick();
        tick();
        reset = 1'b0;

        // ALU ops, back to back
        for (int i = 0; i < 12; i++) begin
            send(32'h1c000000 + 32'(i * 4), v_op[i], v_s1[i], v_s2[i], 32'd0,
                 3'd0, 5'd0, 8'h23, 86'd0);
            @(negedge clk);
            check($sformatf("alu_res_%0d", i), EX_rf_bus[31:0], v_res[i]);
            check($sformatf("alu_valid_%0d", i), EX_MEM_valid, 1'b1);
            check($sformatf("alu_noreq_%0d", i), data_sram_req, 1'b0);
        end
        check("alu_ctrl", EX_rf_bus[39:32], 8'h23);
        check("alu_pc",   EX_pc, 32'h1c00002c);
        tick();
        @(negedge clk);
        check("alu_drain", EX_MEM_valid, 1'b0);

        // st_b to 0x1003, zero-wait
        send(32'h1c000100, OP_ADD, 32'h1000, 32'h3, 32'h000000ab, 3'b001, 5'd0, 8'h00, 86'd0);
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        check("stb_req",   data_sram_req,   1'b1);
        check("stb_wr",    data_sram_wr,    1'b1);
        check("stb_addr",  data_sram_addr,  32'h1003);
        check("stb_wstrb", data_sram_wstrb, 4'b1000);
        check("stb_wdata", data_sram_wdata, 32'habababab);
        check("stb_size",  data_sram_size,  2'd0);
        check("stb_exreq", EX_req,          1'b1);
        check("stb_valid", EX_MEM_valid,    1'b1);
        tick();
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check("stb_after_req", data_sram_req, 1'b0);

        // ld_w at 0x2004 with 3 wait cycles, then MEM stalls for 2 cycles
        send(32'h1c000200, OP_ADD, 32'h2000, 32'h4, 32'd0, 3'd0, 5'b10000, 8'h67, 86'd0);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            check($sformatf("ldw_wait_req_%0d", c),   data_sram_req,  1'b1);
            check($sformatf("ldw_wait_addr_%0d", c),  data_sram_addr, 32'h2004);
            check($sformatf("ldw_wait_valid_%0d", c), EX_MEM_valid,   1'b0);
        end
        check("ldw_size", data_sram_size, 2'd2);
        check("ldw_wr",   data_sram_wr,   1'b0);
        tick();
        data_sram_addr_ok = 1'b1;
        MEM_allowin       = 1'b0;
        @(negedge clk);
        check("ldw_ok_req",   data_sram_req, 1'b1);
        check("ldw_ok_valid", EX_MEM_valid,  1'b1);
        check("ldw_ok_exreq", EX_req,        1'b1);
        for (int c = 0; c < 2; c++) begin
            tick();
            data_sram_addr_ok = 1'b0;
            @(negedge clk);
            check($sformatf("ldw_stall_req_%0d", c),     data_sram_req, 1'b0);
            check($sformatf("ldw_stall_valid_%0d", c),   EX_MEM_valid,  1'b1);
            check($sformatf("ldw_stall_exreq_%0d", c),   EX_req,        1'b1);
            check($sformatf("ldw_stall_allowin_%0d", c), EX_allowin,    1'b0);
        end
        check("ldw_ldinst", EX_mem_ld_inst,   5'b10000);
        check("ldw_ctrl",   EX_rf_bus[39:32], 8'h67);
        tick();
        MEM_allowin = 1'b1;
        @(negedge clk);
        check("ldw_leave_valid",   EX_MEM_valid, 1'b1);
        check("ldw_leave_allowin", EX_allowin,   1'b1);
        tick();
        @(negedge clk);
        check("ldw_gone_valid", EX_MEM_valid,  1'b0);
        check("ldw_gone_req",   data_sram_req, 1'b0);

        // ld_h at 0x2001 (misaligned)
        send(32'h1c000300, OP_ADD, 32'h2000, 32'h1, 32'd0, 3'd0, 5'b00100, 8'h68, 86'd0);
        @(negedge clk);
`ifdef EX_ALE_CHECK_EN
        check("ale_bit",   EX_except_bus, {1'b1, 85'd0});
        check("ale_req",   data_sram_req, 1'b0);
        check("ale_exreq", EX_req,        1'b0);
        check("ale_valid", EX_MEM_valid,  1'b1);
        tick();
        @(negedge clk);
        check("ale_after_req", data_sram_req, 1'b0);
`else
        check("ldh_req",  data_sram_req,     1'b1);
        check("ldh_size", data_sram_size,    2'd1);
        check("ldh_addr", data_sram_addr,    32'h2001);
        check("ldh_ale",  EX_except_bus[85], 1'b0);
        tick();
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        check("ldh_ok_exreq", EX_req,       1'b1);
        check("ldh_ok_valid", EX_MEM_valid, 1'b1);
        tick();
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check("ldh_after_req", data_sram_req, 1'b0);
`endif

        // MEM exception suppresses the request in IDLE
        MEM_EXC_signal = 1'b1;
        send(32'h1c000400, OP_ADD, 32'h5000, 32'h0, 32'd0, 3'd0, 5'b10000, 8'h61, 86'd0);
        @(negedge clk);
        check("memexc_req",   data_sram_req, 1'b0);
        check("memexc_exreq", EX_req,        1'b0);
        check("memexc_valid", EX_MEM_valid,  1'b1);
        tick();
        MEM_EXC_signal = 1'b0;

        // Own exception on the bus suppresses the request
        send(32'h1c000500, OP_ADD, 32'h6000, 32'h0, 32'h1, 3'b100, 5'd0, 8'h00, 86'h400);
        @(negedge clk);
        check("exc_req", data_sram_req, 1'b0);
        check("exc_bus", EX_except_bus, 86'h400);
        tick();

        // Flush while in REQ, with a new instruction offered in the flush cycle
        send(32'h1c000600, OP_ADD, 32'h3000, 32'h0, 32'h11223344, 3'b100, 5'd0, 8'h00, 86'd0);
        @(negedge clk);
        check("fl_req0",   data_sram_req,   1'b1);
        check("fl_wstrb0", data_sram_wstrb, 4'hf);
        tick();
        WB_EXC_signal = 1'b1;
        ID_EX_valid   = 1'b1;
        ID_pc         = 32'h1c000ea0;
        ID_alu_src1   = 32'h9000;
        ID_st_op      = 3'd0;
        @(negedge clk);
        check("fl_req1",  data_sram_req,  1'b1);
        check("fl_addr1", data_sram_addr, 32'h3000);
        tick();
        WB_EXC_signal = 1'b0;
        ID_EX_valid   = 1'b0;
        @(negedge clk);
        check("fl_req2",   data_sram_req,   1'b1);
        check("fl_addr2",  data_sram_addr,  32'h3000);
        check("fl_wdata2", data_sram_wdata, 32'h11223344);
        check("fl_pc2",    EX_pc,           32'h1c000600);
        check("fl_valid2", EX_MEM_valid,    1'b0);
        tick();
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        check("fl_req3",   data_sram_req, 1'b1);
        check("fl_valid3", EX_MEM_valid,  1'b0);
        tick();
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check("fl_req4",     data_sram_req, 1'b0);
        check("fl_valid4",   EX_MEM_valid,  1'b0);
        check("fl_allowin4", EX_allowin,    1'b1);

        // Reset asserted while parked in DONE
        MEM_allowin = 1'b0;
        send(32'h1c000700, OP_ADD, 32'h4000, 32'h0, 32'd0, 3'd0, 5'b10000, 8'h62, 86'd0);
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        check("rd_exreq0", EX_req, 1'b1);
        tick();
        data_sram_addr_ok = 1'b0;
        @(negedge clk);
        check("rd_req1",   data_sram_req, 1'b0);
        check("rd_exreq1", EX_req,        1'b1);
        check("rd_valid1", EX_MEM_valid,  1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rd_valid",   EX_MEM_valid,  1'b0);
        check("rd_exreq",   EX_req,        1'b0);
        check("rd_req",     data_sram_req, 1'b0);
        check("rd_pc",      EX_pc,         32'd0);
        check("rd_exc",     EX_except_bus, 86'd0);
        check("rd_rfbus",   EX_rf_bus,     40'd0);
        check("rd_allowin", EX_allowin,    1'b1);
        tick();
        reset       = 1'b0;
        MEM_allowin = 1'b1;
        @(negedge clk);
        check("rd_post_req", data_sram_req, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
